// File: rtl/noc_lsu_pkg.sv
// noc_lsu_pkg: shared codes, types and generic header packing for the LSU packetizer
package noc_lsu_pkg;

    localparam int HDR_MAX = 128;
    localparam logic [2:0] NOC_CLASS_LSU = 3'h2;
    localparam logic SINGLE = 1'b0;
    localparam logic BURST = 1'b1;

    typedef enum logic [2:0] {READREQ = 3'd0, WRITEREQ = 3'd1, READRESP = 3'd2} msgtype_e;
    typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_e;

    function automatic logic [HDR_MAX-1:0] fld(input logic [HDR_MAX-1:0] v, input int w);
        return v & ((HDR_MAX'(1) << w) - HDR_MAX'(1));
    endfunction

    // Fields are packed from bit fw-1 downward; the length occupies the LSBs with zero padding above it.
    function automatic logic [HDR_MAX-1:0] pack_hdr(
        input int fw, input int dw, input int cw, input int sw, input int mw, input int lw,
        input logic [HDR_MAX-1:0] dest, input logic [HDR_MAX-1:0] cls,
        input logic [HDR_MAX-1:0] src, input logic [HDR_MAX-1:0] mt,
        input logic size, input logic [HDR_MAX-1:0] len
    );
        int pos;
        logic [HDR_MAX-1:0] h;
        pos = fw - dw;
        h = fld(dest, dw) << pos;
        pos = pos - cw;
        h = h | (fld(cls, cw) << pos);
        pos = pos - sw;
        h = h | (fld(src, sw) << pos);
        pos = pos - mw;
        h = h | (fld(mt, mw) << pos);
        pos = pos - 1;
        h = h | (HDR_MAX'(size) << pos);
        return h | fld(len, lw);
    endfunction

endpackage

// File: rtl/noc_lsu_packetizer.sv
// noc_lsu_packetizer: serialises LSU read/write requests into header/address/data NoC flits.
// Optional statistics counters are enabled by defining NOC_LSU_PKT_STATS_EN.
module noc_lsu_packetizer #(
    parameter int FLIT_WIDTH    = 32,
    parameter int DEST_WIDTH    = 5,
    parameter int CLASS_WIDTH   = 3,
    parameter int SRC_WIDTH     = 5,
    parameter int MSGTYPE_WIDTH = 3,
    parameter int MAX_LEN       = 32,
    parameter int TILE_ID       = 0,
    parameter int LEN_WIDTH     = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DEST_WIDTH-1:0] req_dest,
    input  logic [FLIT_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [FLIT_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    output logic                  err_len
`ifdef NOC_LSU_PKT_STATS_EN
    ,
    output logic [31:0]           stat_pkt_cnt,
    output logic [31:0]           stat_flit_cnt
`endif
);
    import noc_lsu_pkg::*;

    localparam logic [LEN_WIDTH-1:0] LEN_CAP = LEN_WIDTH'(MAX_LEN - 2);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    if (DEST_WIDTH + CLASS_WIDTH + SRC_WIDTH + MSGTYPE_WIDTH + 1 + LEN_WIDTH > FLIT_WIDTH) begin : g_hdr_too_wide
        $error("noc_lsu_packetizer: header fields do not fit in FLIT_WIDTH");
    end

    state_e state_q, state_d;
    logic we_q, err_q, accept, clamp, hs;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [FLIT_WIDTH-1:0] addr_q, hdr;
    logic [LEN_WIDTH-1:0] cnt_q, eff_len;

    assign accept  = req_valid && req_ready;
    assign hs      = noc_out_valid && noc_out_ready;
    assign clamp   = req_len > LEN_CAP;
    assign eff_len = req_len == '0 ? LEN_ONE : clamp ? LEN_CAP : req_len;
    assign err_len = err_q;
    // cnt_q holds the full length until DATA starts, so it doubles as the header length field
    assign hdr = FLIT_WIDTH'(pack_hdr(FLIT_WIDTH, DEST_WIDTH, CLASS_WIDTH, SRC_WIDTH, MSGTYPE_WIDTH, LEN_WIDTH,
                                      HDR_MAX'(dest_q), HDR_MAX'(NOC_CLASS_LSU), HDR_MAX'(TILE_ID),
                                      HDR_MAX'(we_q ? WRITEREQ : READREQ),
                                      cnt_q == LEN_ONE ? SINGLE : BURST, HDR_MAX'(cnt_q)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next-state: each flit phase advances only on its handshake
    always_comb begin
        state_d = state_q == IDLE ? (accept ? HDR : IDLE)
                : state_q == HDR  ? (hs ? ADDR : HDR)
                : state_q == ADDR ? (hs ? (we_q ? DATA : IDLE) : ADDR)
                : (hs && noc_out_last ? IDLE : DATA);
    end

    // Outputs: DATA is a combinational pass-through of the write-data stream
    always_comb begin
        req_ready     = !rst && state_q == IDLE;
        noc_out_valid = state_q == HDR || state_q == ADDR || (state_q == DATA && wdata_valid);
        noc_out_flit  = state_q == HDR ? hdr : state_q == ADDR ? addr_q : state_q == DATA ? wdata : '0;
        noc_out_last  = state_q == ADDR ? !we_q : (state_q == DATA && cnt_q == LEN_ONE);
        wdata_ready   = state_q == DATA && noc_out_ready;
    end

    // Request capture, remaining-word counter and clamp flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            dest_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            err_q <= accept && clamp;
            if (accept) begin
                we_q   <= req_we;
                dest_q <= req_dest;
                addr_q <= req_addr;
                cnt_q  <= eff_len;
            end else if (state_q == DATA && hs) begin
                cnt_q <= cnt_q - LEN_ONE;
            end
        end
    end

`ifdef NOC_LSU_PKT_STATS_EN
    logic [31:0] stat_pkt_q, stat_flit_q;
    assign stat_pkt_cnt  = stat_pkt_q;
    assign stat_flit_cnt = stat_flit_q;

    // Wrapping packet and flit handshake counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_q  <= '0;
            stat_flit_q <= '0;
        end else begin
            stat_pkt_q  <= stat_pkt_q + 32'(hs && noc_out_last);
            stat_flit_q <= stat_flit_q + 32'(hs);
        end
    end
`endif

endmodule

// File: tb/tb_noc_lsu_packetizer.sv
// tb_noc_lsu_packetizer: directed and randomized packet checks against an expected-flit model
`timescale 1ns/1ps
module tb_noc_lsu_packetizer;
  localparam int TILE = 0;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, wdata_valid = 1'b0, noc_out_ready = 1'b0;
  logic [4:0] req_dest = '0, req_len = '0;
  logic [31:0] req_addr = '0, wdata = '0;
  logic req_ready, wdata_ready, noc_out_last, noc_out_valid, err_len;
  logic [31:0] noc_out_flit;
`ifdef NOC_LSU_PKT_STATS_EN
  logic [31:0] stat_pkt_cnt, stat_flit_cnt;
  int exp_pkt = 0, exp_flit = 0;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  noc_lsu_packetizer #(.TILE_ID(TILE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_dest(req_dest), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .err_len(err_len)
`ifdef NOC_LSU_PKT_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_flit_cnt(stat_flit_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] hdr_model(input logic [4:0] d, input logic we, input int l);
    return (32'(d) << 27) | (32'd2 << 24) | (32'(TILE) << 19) | (32'(we) << 16)
         | (l > 1 ? 32'h8000 : 32'h0) | 32'(l);
  endfunction
  task automatic run_pkt(input logic we, input logic [4:0] dest, input logic [31:0] addr,
                         input logic [4:0] len, input int mode, input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] words[$];
    int eff, n, got, widx, c;
    logic clamp, rdy;
    eff = len == 0 ? 1 : (len > 30 ? 30 : int'(len));
    clamp = len > 30;
    exp_q.push_back(hdr_model(dest, we, eff));
    exp_q.push_back(addr);
    if (we) for (int i = 0; i < eff; i++) begin
      words.push_back($urandom);
      exp_q.push_back(words[i]);
    end
    n = exp_q.size();
    got = 0;
    widx = 0;
    req_valid = 1'b1; req_we = we; req_dest = dest; req_addr = addr; req_len = len;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_dest = 5'($urandom); req_addr = $urandom; req_len = 5'($urandom);
    for (c = 0; got < n && c < 2000; c++) begin
      if (got == abort_at) break;
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      noc_out_ready = rdy;
      wdata = (we && widx < eff) ? words[widx] : $urandom;
      wdata_valid = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("err_len", err_len, (c == 0) && clamp);
      chk("busy_ready", req_ready, 1'b0);
      chk("valid", noc_out_valid, got < 2 ? 1'b1 : wdata_valid);
      chk("wdata_ready", wdata_ready, got >= 2 && rdy);
      if (noc_out_valid) begin
        chk("flit", noc_out_flit, exp_q[got]);
        chk("last", noc_out_last, got == n - 1);
      end
      if (noc_out_valid && rdy) begin
`ifdef NOC_LSU_PKT_STATS_EN
        exp_flit++;
        if (got == n - 1) exp_pkt++;
`endif
        got++;
      end
      if (wdata_valid && wdata_ready) widx++;
      @(posedge clk); @(negedge clk);
    end
    if (abort_at >= 0 && got == abort_at) begin
      rst = 1'b1;
      #1 chk("rst_req_ready", req_ready, 1'b0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_valid_drop", noc_out_valid, 1'b0);
      chk("rst_idle_ready", req_ready, 1'b1);
`ifdef NOC_LSU_PKT_STATS_EN
      exp_pkt = 0;
      exp_flit = 0;
`endif
    end else begin
      chk("no_timeout", c < 2000, 1'b1);
      chk("flit_count", got, n);
      chk("words_used", widx, we ? eff : 0);
      noc_out_ready = 1'($urandom_range(0, 1));
      #1 chk("bubble_ready", req_ready, 1'b1);
      chk("bubble_valid", noc_out_valid, 1'b0);
      chk("bubble_err", err_len, 1'b0);
`ifdef NOC_LSU_PKT_STATS_EN
      chk("stat_pkt", stat_pkt_cnt, 32'(exp_pkt));
      chk("stat_flit", stat_flit_cnt, 32'(exp_flit));
`endif
    end
  endtask
  initial begin
    noc_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_valid", noc_out_valid, 1'b0);
    chk("rst_last", noc_out_last, 1'b0);
    chk("rst_flit", noc_out_flit, 32'h0);
    chk("rst_wdata_ready", wdata_ready, 1'b0);
    chk("rst_err", err_len, 1'b0);
    rst = 1'b0;
    #1 chk("idle_ready", req_ready, 1'b1);
    run_pkt(1'b0, 5'd3, 32'h1000, 5'd1, 0, -1);
    run_pkt(1'b1, 5'd1, 32'h2000, 5'd4, 0, -1);
`ifdef NOC_LSU_PKT_STATS_EN
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_pkt = 0;
    exp_flit = 0;
    run_pkt(1'b0, 5'd2, 32'h40, 5'd1, 0, -1);
    run_pkt(1'b1, 5'd2, 32'h80, 5'd2, 0, -1);
    chk("stat_pkt_two", stat_pkt_cnt, 32'd2);
    chk("stat_flit_six", stat_flit_cnt, 32'd6);
`endif
    run_pkt(1'b1, 5'd7, 32'h3000, 5'd3, 1, -1);
    run_pkt(1'b1, 5'd9, 32'h4000, 5'd31, 0, -1);
    run_pkt(1'b1, 5'd4, 32'h5000, 5'd0, 1, -1);
    run_pkt(1'b0, 5'd5, 32'h6000, 5'd30, 0, -1);
    run_pkt(1'b1, 5'd6, 32'h7000, 5'd4, 0, 3);
    run_pkt(1'b0, 5'd8, 32'h8000, 5'd2, 0, -1);
    for (int k = 0; k < 20; k++)
      run_pkt(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 2, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
